// File: rtl/obstacle_scroller_pkg.sv
// obstacle_scroller_pkg: shared game constants, coordinate type and one-hot state encoding
package obstacle_scroller_pkg;
  localparam int COORD_W = 10;
  localparam int SCREEN_W_D = 640;
  localparam int GROUND_Y_D = 440;
  localparam int OBS_W_D = 20;
  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RUN    = 4'b0010,
    ST_GAP    = 4'b0100,
    ST_FREEZE = 4'b1000
  } state_t;
endpackage

// File: rtl/obstacle_scroller_if.sv
// obstacle_scroller_if: game control inputs and obstacle/score outputs of the scroller
interface obstacle_scroller_if;
  import obstacle_scroller_pkg::*;
  logic Start;
  logic Frame_Tick;
  logic Lose;
  coord_t X_Edge_Left;
  coord_t X_Edge_Right;
  coord_t Y_Edge_Top;
  logic Obs_Valid;
  logic [15:0] Score;
  logic Q_Idle;
  logic Q_Run;
  logic Q_Gap;
  logic Q_Freeze;
  modport master (
    output Start, Frame_Tick, Lose,
    input X_Edge_Left, X_Edge_Right, Y_Edge_Top, Obs_Valid, Score, Q_Idle, Q_Run, Q_Gap, Q_Freeze
  );
  modport slave (
    input Start, Frame_Tick, Lose,
    output X_Edge_Left, X_Edge_Right, Y_Edge_Top, Obs_Valid, Score, Q_Idle, Q_Run, Q_Gap, Q_Freeze
  );
endinterface

// File: rtl/obstacle_scroller_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, taps 8,6,5,4; never reaches zero from a nonzero seed
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);
  always_ff @(posedge Clk or posedge reset)
    if (reset) q <= SEED;
    else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: spawns, scrolls and respawns the single obstacle and keeps the passed score
module obstacle_scroller
  import obstacle_scroller_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_D,
  parameter int GROUND_Y = GROUND_Y_D,
  parameter int OBS_W = OBS_W_D,
  parameter int SPEED = 4,
  parameter int MIN_H = 16,
  parameter int GAP_FRAMES = 30,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic Clk,
  input logic reset,
  obstacle_scroller_if.slave bus
);
  if (SCREEN_W + OBS_W > 1023 || GROUND_Y < MIN_H + 63 || GAP_FRAMES < 1) begin : g_bad_params
    $error("obstacle_scroller: parameters overflow 10-bit coordinates or GAP_FRAMES < 1");
  end
  localparam coord_t PARK_L = coord_t'(SCREEN_W);
  localparam coord_t PARK_R = coord_t'(SCREEN_W + OBS_W);
  localparam coord_t PARK_T = coord_t'(GROUND_Y);
  localparam coord_t TOP_BASE = coord_t'(GROUND_Y - MIN_H);
  localparam coord_t STEP = coord_t'(SPEED);
  localparam logic [15:0] GAP = 16'(GAP_FRAMES);
  state_t r_state, w_state;
  coord_t r_left, r_right, r_top, w_left, w_right, w_top, w_spawn_top;
  logic r_valid, w_valid, w_spawn, w_park;
  logic [15:0] r_score, w_score, r_gap, w_gap;
  logic [7:0] w_lfsr, w_rand;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .reset(reset), .en(bus.Frame_Tick), .q(w_lfsr));
  assign w_rand = w_lfsr & 8'h3F;
  assign w_spawn_top = TOP_BASE - {2'b00, w_rand};
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_left <= PARK_L;
      r_right <= PARK_R;
      r_top <= PARK_T;
      r_valid <= 1'b0;
      r_score <= '0;
      r_gap <= '0;
    end else begin
      r_state <= w_state;
      r_left <= w_left;
      r_right <= w_right;
      r_top <= w_top;
      r_valid <= w_valid;
      r_score <= w_score;
      r_gap <= w_gap;
    end
  // Lose is tested before Frame_Tick so a colliding frame neither moves, scores nor spawns
  always_comb begin
    w_state = r_state;
    w_left = r_left;
    w_right = r_right;
    w_top = r_top;
    w_valid = r_valid;
    w_score = r_score;
    w_gap = r_gap;
    w_spawn = 1'b0;
    w_park = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.Start) begin
        w_spawn = 1'b1;
        w_score = '0;
        w_state = ST_RUN;
      end
      ST_RUN: if (bus.Lose) w_state = ST_FREEZE;
      else if (bus.Frame_Tick) begin
        if (r_right <= STEP) begin
          w_park = 1'b1;
          w_score = (&r_score) ? r_score : r_score + 16'd1;
          w_gap = GAP;
          w_state = ST_GAP;
        end else begin
          w_right = r_right - STEP;
          w_left = (r_left < STEP) ? '0 : r_left - STEP;
        end
      end
      ST_GAP: if (bus.Lose) w_state = ST_FREEZE;
      else if (bus.Frame_Tick) begin
        w_gap = r_gap - 16'd1;
        if (r_gap == 16'd1) begin
          w_spawn = 1'b1;
          w_state = ST_RUN;
        end
      end
      ST_FREEZE: if (bus.Start) begin
        w_park = 1'b1;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_spawn) begin
      w_left = PARK_L;
      w_right = PARK_R;
      w_top = w_spawn_top;
      w_valid = 1'b1;
    end
    if (w_park) begin
      w_left = PARK_L;
      w_right = PARK_R;
      w_top = PARK_T;
      w_valid = 1'b0;
    end
  end
  assign bus.X_Edge_Left = r_left;
  assign bus.X_Edge_Right = r_right;
  assign bus.Y_Edge_Top = r_top;
  assign bus.Obs_Valid = r_valid;
  assign bus.Score = r_score;
  assign bus.Q_Idle = r_state[0];
  assign bus.Q_Run = r_state[1];
  assign bus.Q_Gap = r_state[2];
  assign bus.Q_Freeze = r_state[3];
endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: directed scenarios plus randomized play checked against a behavioural game model
module tb_obstacle_scroller;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 Clk = ~Clk;
  obstacle_scroller_if sif ();
  obstacle_scroller_if cif ();
  obstacle_scroller dut (.Clk(Clk), .reset(reset), .bus(sif));
  obstacle_scroller #(.SCREEN_W(642)) dut_c (.Clk(Clk), .reset(reset), .bus(cif));
  // model: 0 idle, 1 run, 2 gap, 3 freeze
  int m_st, m_gap;
  logic [9:0] m_l, m_r, m_t;
  logic m_v;
  logic [15:0] m_sc;
  logic [7:0] m_lf;
  function automatic logic [3:0] q_dut();
    return {sif.Q_Freeze, sif.Q_Gap, sif.Q_Run, sif.Q_Idle};
  endfunction
  task automatic model_reset();
    m_st = 0; m_gap = 0; m_l = 640; m_r = 660; m_t = 440; m_v = 0; m_sc = 0; m_lf = 8'hA5;
  endtask
  task automatic model_park();
    m_l = 640; m_r = 660; m_t = 440; m_v = 0;
  endtask
  task automatic model_step(input logic s, input logic t, input logic l);
    logic [7:0] lf;
    lf = m_lf;
    case (m_st)
      0: if (s) begin
        m_l = 640; m_r = 660; m_t = 10'(440 - 16 - int'(lf % 64)); m_v = 1; m_sc = 0; m_st = 1;
      end
      1: if (l) m_st = 3;
      else if (t) begin
        if (m_r <= 4) begin
          if (m_sc != 16'hFFFF) m_sc = m_sc + 1;
          model_park(); m_gap = 30; m_st = 2;
        end else begin
          m_r = m_r - 4;
          m_l = (m_l < 4) ? 10'd0 : m_l - 4;
        end
      end
      2: if (l) m_st = 3;
      else if (t) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_l = 640; m_r = 660; m_t = 10'(440 - 16 - int'(lf % 64)); m_v = 1; m_st = 1;
        end
      end
      default: if (s) begin model_park(); m_st = 0; end
    endcase
    if (t) m_lf = {lf[6:0], ^(lf & 8'hB8)};
  endtask
  task automatic cyc(input logic s, input logic t, input logic l);
    sif.Start = s; sif.Frame_Tick = t; sif.Lose = l;
    @(posedge Clk);
    model_step(s, t, l);
    #1;
    sif.Start = 0; sif.Frame_Tick = 0; sif.Lose = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 0;
    model_reset();
    #1;
    n_tests++; if (q_dut() !== 4'b0001) begin n_fail++; $display("FAIL reset_state got %b want 0001", q_dut()); end
    n_tests++; if (sif.X_Edge_Left !== 10'd640 || sif.X_Edge_Right !== 10'd660 || sif.Y_Edge_Top !== 10'd440) begin
      n_fail++; $display("FAIL reset_edges got %0d/%0d/%0d want 640/660/440", sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top); end
    n_tests++; if (sif.Obs_Valid !== 1'b0 || sif.Score !== 16'd0) begin
      n_fail++; $display("FAIL reset_valid_score got %b/%0d want 0/0", sif.Obs_Valid, sif.Score); end
  endtask
  task automatic test_spawn();
    cyc(1, 0, 0);
    n_tests++; if (q_dut() !== 4'b0010) begin n_fail++; $display("FAIL spawn_state got %b want 0010", q_dut()); end
    n_tests++; if (sif.X_Edge_Left !== 10'd640 || sif.X_Edge_Right !== 10'd660 || sif.Y_Edge_Top !== 10'd387) begin
      n_fail++; $display("FAIL spawn_edges got %0d/%0d/%0d want 640/660/387", sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top); end
    n_tests++; if (sif.Obs_Valid !== 1'b1 || sif.Score !== 16'd0) begin
      n_fail++; $display("FAIL spawn_valid_score got %b/%0d want 1/0", sif.Obs_Valid, sif.Score); end
  endtask
  task automatic test_scroll();
    repeat (10) cyc(0, 1, 0);
    n_tests++; if (sif.X_Edge_Left !== 10'd600 || sif.X_Edge_Right !== 10'd620 || sif.Y_Edge_Top !== 10'd387) begin
      n_fail++; $display("FAIL scroll10 got %0d/%0d/%0d want 600/620/387", sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top); end
  endtask
  task automatic test_despawn_gap();
    for (int i = 0; i < 200 && sif.X_Edge_Right != 10'd4; i++) cyc(0, 1, 0);
    n_tests++; if (sif.X_Edge_Right !== 10'd4 || sif.X_Edge_Left !== 10'd0) begin
      n_fail++; $display("FAIL reach_right4 got %0d/%0d want 0/4", sif.X_Edge_Left, sif.X_Edge_Right); end
    cyc(0, 1, 0);
    n_tests++; if (q_dut() !== 4'b0100 || sif.Score !== 16'd1 || sif.Obs_Valid !== 1'b0) begin
      n_fail++; $display("FAIL despawn got q=%b score=%0d valid=%b want 0100/1/0", q_dut(), sif.Score, sif.Obs_Valid); end
    n_tests++; if (sif.X_Edge_Left !== 10'd640 || sif.Y_Edge_Top !== 10'd440) begin
      n_fail++; $display("FAIL despawn_park got %0d/%0d want 640/440", sif.X_Edge_Left, sif.Y_Edge_Top); end
    repeat (29) cyc(0, 1, 0);
    n_tests++; if (q_dut() !== 4'b0100 || sif.Obs_Valid !== 1'b0) begin
      n_fail++; $display("FAIL gap_29 got q=%b valid=%b want 0100/0", q_dut(), sif.Obs_Valid); end
    cyc(0, 1, 0);
    n_tests++; if (q_dut() !== 4'b0010 || sif.Obs_Valid !== 1'b1 || sif.Y_Edge_Top !== m_t || sif.X_Edge_Left !== 10'd640) begin
      n_fail++; $display("FAIL respawn got q=%b valid=%b top=%0d left=%0d want 0010/1/%0d/640", q_dut(), sif.Obs_Valid, sif.Y_Edge_Top, sif.X_Edge_Left, m_t); end
  endtask
  task automatic test_clamp();
    cif.Start = 1;
    @(posedge Clk); #1;
    cif.Start = 0; cif.Frame_Tick = 1;
    repeat (160) @(posedge Clk);
    #1;
    n_tests++; if (cif.X_Edge_Left !== 10'd2 || cif.X_Edge_Right !== 10'd22) begin
      n_fail++; $display("FAIL clamp_pre got %0d/%0d want 2/22", cif.X_Edge_Left, cif.X_Edge_Right); end
    @(posedge Clk); #1;
    cif.Frame_Tick = 0;
    n_tests++; if (cif.X_Edge_Left !== 10'd0 || cif.X_Edge_Right !== 10'd18) begin
      n_fail++; $display("FAIL clamp got %0d/%0d want 0/18", cif.X_Edge_Left, cif.X_Edge_Right); end
  endtask
  task automatic test_freeze();
    repeat (85) cyc(0, 1, 0);
    n_tests++; if (sif.X_Edge_Left !== 10'd300) begin n_fail++; $display("FAIL pre_freeze left got %0d want 300", sif.X_Edge_Left); end
    cyc(0, 1, 1);
    n_tests++; if (q_dut() !== 4'b1000 || sif.X_Edge_Left !== 10'd300 || sif.X_Edge_Right !== 10'd320) begin
      n_fail++; $display("FAIL freeze got q=%b %0d/%0d want 1000 300/320", q_dut(), sif.X_Edge_Left, sif.X_Edge_Right); end
    repeat (5) cyc(0, 1, 0);
    n_tests++; if (q_dut() !== 4'b1000 || sif.X_Edge_Left !== 10'd300 || sif.Score !== 16'd1 || sif.Obs_Valid !== 1'b1) begin
      n_fail++; $display("FAIL freeze_hold got q=%b left=%0d score=%0d valid=%b want 1000/300/1/1", q_dut(), sif.X_Edge_Left, sif.Score, sif.Obs_Valid); end
    cyc(1, 0, 0);
    n_tests++; if (q_dut() !== 4'b0001 || sif.X_Edge_Left !== 10'd640 || sif.X_Edge_Right !== 10'd660 || sif.Y_Edge_Top !== 10'd440 || sif.Obs_Valid !== 1'b0 || sif.Score !== 16'd1) begin
      n_fail++; $display("FAIL restart_idle got q=%b %0d/%0d/%0d valid=%b score=%0d want 0001 640/660/440 0 1", q_dut(), sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top, sif.Obs_Valid, sif.Score); end
    cyc(1, 0, 0);
    n_tests++; if (q_dut() !== 4'b0010 || sif.Score !== 16'd0 || sif.Y_Edge_Top !== m_t) begin
      n_fail++; $display("FAIL restart_run got q=%b score=%0d top=%0d want 0010/0/%0d", q_dut(), sif.Score, sif.Y_Edge_Top, m_t); end
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 399) == 0);
      n_tests++;
      if (q_dut() !== 4'(1 << m_st) || sif.X_Edge_Left !== m_l || sif.X_Edge_Right !== m_r ||
          sif.Y_Edge_Top !== m_t || sif.Obs_Valid !== m_v || sif.Score !== m_sc) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL random cyc %0d got q=%b %0d/%0d/%0d v=%b s=%0d want q=%b %0d/%0d/%0d v=%b s=%0d", i, q_dut(),
                   sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top, sif.Obs_Valid, sif.Score, 4'(1 << m_st), m_l, m_r, m_t, m_v, m_sc);
      end
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 1000 && m_st != 2; i++) cyc(m_st == 0 || m_st == 3, 1, 0);
    n_tests++; if (m_st != 2 || q_dut() !== 4'b0100 || sif.Score == 16'd0) begin
      n_fail++; $display("FAIL reach_gap got q=%b score=%0d want 0100 with nonzero score", q_dut(), sif.Score); end
    @(negedge Clk);
    reset = 1;
    #1;
    n_tests++; if (q_dut() !== 4'b0001 || sif.X_Edge_Left !== 10'd640 || sif.X_Edge_Right !== 10'd660 ||
                   sif.Y_Edge_Top !== 10'd440 || sif.Obs_Valid !== 1'b0 || sif.Score !== 16'd0) begin
      n_fail++; $display("FAIL async_reset got q=%b %0d/%0d/%0d v=%b s=%0d want 0001 640/660/440 0 0", q_dut(),
                         sif.X_Edge_Left, sif.X_Edge_Right, sif.Y_Edge_Top, sif.Obs_Valid, sif.Score); end
    @(negedge Clk);
    reset = 0;
    model_reset();
    cyc(1, 0, 0);
    n_tests++; if (sif.Y_Edge_Top !== 10'd387 || q_dut() !== 4'b0010) begin
      n_fail++; $display("FAIL post_reset_spawn got top=%0d q=%b want 387/0010", sif.Y_Edge_Top, q_dut()); end
  endtask
  initial begin
    sif.Start = 0; sif.Frame_Tick = 0; sif.Lose = 0;
    cif.Start = 0; cif.Frame_Tick = 0; cif.Lose = 0;
    model_reset();
    test_reset();
    test_spawn();
    test_scroll();
    test_despawn_gap();
    test_clamp();
    test_freeze();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
